// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, frame width and the default baud divisor
// used by both the receiver and the transmitter.
package uart_pkg;

    localparam int DATA_BITS            = 8;
    localparam int BIT_IDX_W            = $clog2(DATA_BITS);
    localparam int CLKS_PER_BAUD_115200 = 868;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BRK   = 3'd4
    } rx_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Byte delivery interface of the UART receiver: holding-register handshake, error pulses
// and status.
interface uart_rx_if;
    import uart_pkg::*;

    // Handshake: a byte moves on every rising clock edge where o_rx_valid and i_rx_ready are
    // both 1. o_rx_valid never drops and o_rx_data never changes until that transfer;
    // i_rx_ready may change freely and does not depend on o_rx_valid.
    logic [DATA_BITS-1:0] o_rx_data;
    logic                 o_rx_valid;
    logic                 i_rx_ready;
    logic                 o_frame_err;
    logic                 o_overrun;
    logic                 o_busy;
    rx_state_e            o_dbg_state;

    modport master (
        output o_rx_data,
        output o_rx_valid,
        input  i_rx_ready,
        output o_frame_err,
        output o_overrun,
        output o_busy,
        output o_dbg_state
    );

    modport slave (
        input  o_rx_data,
        input  o_rx_valid,
        output i_rx_ready,
        input  o_frame_err,
        input  o_overrun,
        input  o_busy,
        input  o_dbg_state
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input; RESET_VAL is the level both
// flops hold in reset, so an idle-high line does not look like an edge after reset.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling from a baud down-counter, one-entry holding register
// with valid/ready delivery, framing-error and overrun pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BAUD = CLKS_PER_BAUD_115200,
    parameter int CNT_W         = 10
) (
    input  logic     master_clk_i,
    input  logic     rst_n_i,
    input  logic     i_uart_rx,
    uart_rx_if.master rx_if
);

    localparam int                   HALF_BAUD = CLKS_PER_BAUD / 2;
    localparam logic [CNT_W-1:0]     HALF_M1   = CNT_W'(HALF_BAUD - 1);
    localparam logic [CNT_W-1:0]     FULL_M1   = CNT_W'(CLKS_PER_BAUD - 1);
    localparam logic [CNT_W-1:0]     CNT_ONE   = CNT_W'(1);
    localparam logic [BIT_IDX_W-1:0] LAST_BIT  = BIT_IDX_W'(DATA_BITS - 1);
    localparam logic [BIT_IDX_W-1:0] IDX_ONE   = BIT_IDX_W'(1);

    rx_state_e            r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [BIT_IDX_W-1:0] r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_busy;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_frame_err;
    logic                 r_overrun;

    rx_state_e            w_state_nxt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic [BIT_IDX_W-1:0] w_bit_idx_nxt;
    logic [DATA_BITS-1:0] w_shift_nxt;
    logic                 w_rx_s;
    logic                 w_cnt_zero;
    logic                 w_good_stop;
    logic                 w_bad_stop;
    logic                 w_xfer;
    logic                 w_load;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync_rx (
        .clk   (master_clk_i),
        .rst_n (rst_n_i),
        .i_d   (i_uart_rx),
        .o_q   (w_rx_s)
    );

    assign w_cnt_zero = (r_cnt == '0);

    always_ff @(posedge master_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shift   <= w_shift_nxt;
            r_busy    <= (w_state_nxt != ST_IDLE);
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_good_stop   = 1'b0;
        w_bad_stop    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_rx_s) begin
                    w_state_nxt = ST_START;
                    w_cnt_nxt   = HALF_M1;
                end
            end
            ST_START: begin
                // A start bit that is gone by its midpoint was a glitch.
                if (w_cnt_zero) begin
                    if (!w_rx_s) begin
                        w_state_nxt   = ST_DATA;
                        w_cnt_nxt     = FULL_M1;
                        w_bit_idx_nxt = '0;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end
            end
            ST_DATA: begin
                if (w_cnt_zero) begin
                    w_shift_nxt   = {w_rx_s, r_shift[DATA_BITS-1:1]};
                    w_cnt_nxt     = FULL_M1;
                    w_bit_idx_nxt = r_bit_idx + IDX_ONE;
                    if (r_bit_idx == LAST_BIT) begin
                        w_state_nxt = ST_STOP;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end
            end
            ST_STOP: begin
                // Leaving at the stop-bit midpoint leaves half a bit to catch the next start.
                if (w_cnt_zero) begin
                    if (w_rx_s) begin
                        w_good_stop = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_bad_stop  = 1'b1;
                        w_state_nxt = ST_BRK;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end
            end
            ST_BRK: begin
                if (w_rx_s) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // A held byte being taken in the same cycle frees the register for the new one.
    assign w_xfer = r_valid & rx_if.i_rx_ready;
    assign w_load = w_good_stop & (~r_valid | rx_if.i_rx_ready);

    always_ff @(posedge master_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_load) begin
                r_data <= r_shift;
            end
            r_valid     <= w_load | (r_valid & ~w_xfer);
            r_frame_err <= w_bad_stop;
            r_overrun   <= w_good_stop & r_valid & ~rx_if.i_rx_ready;
        end
    end

    assign rx_if.o_rx_data   = r_data;
    assign rx_if.o_rx_valid  = r_valid;
    assign rx_if.o_frame_err = r_frame_err;
    assign rx_if.o_overrun   = r_overrun;
    assign rx_if.o_busy      = r_busy;
    assign rx_if.o_dbg_state = r_state;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed scenarios plus randomized frames, checked every cycle against
// a timing-rule model of the receiver and a byte scoreboard.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int CPB   = 16;
    localparam int CNT_W = 5;
    localparam int H     = CPB / 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic line  = 1'b1;
    logic rand_rdy = 1'b0;

    always #5 clk = ~clk;

    uart_rx_if rx_if ();

    uart_rx #(
        .CLKS_PER_BAUD (CPB),
        .CNT_W         (CNT_W)
    ) dut (
        .master_clk_i (clk),
        .rst_n_i      (rst_n),
        .i_uart_rx    (line),
        .rx_if        (rx_if)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic int q_at(input int q[$], input int idx);
        return (idx < q.size()) ? q[idx] : -9999;
    endfunction

    // ---------------- behavioural model ----------------
    int         cyc = 0;
    logic       m_s1 = 1'b1, m_s2 = 1'b1;
    int         m_mode = 0;          // 0 idle, 1 in frame, 2 break
    int         m_t0 = 0;
    logic [7:0] m_byte = '0, m_data = '0;
    logic       m_valid = 1'b0, m_ferr = 1'b0, m_ovr = 1'b0;
    logic [7:0] exp_q[$];

    task automatic model_step();
        logic rs;
        logic good;
        int   k, j;
        cyc++;
        if (!rst_n) begin
            m_s1 = 1'b1; m_s2 = 1'b1; m_mode = 0; m_byte = '0; m_data = '0;
            m_valid = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
            exp_q.delete();
            return;
        end
        good = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
        rs = m_s2; m_s2 = m_s1; m_s1 = line;
        case (m_mode)
            0: if (!rs) begin m_mode = 1; m_t0 = cyc; end
            1: begin
                k = cyc - m_t0;
                if (k == H) begin
                    if (rs) m_mode = 0;
                end else if (k > H && (k - H) % CPB == 0) begin
                    j = (k - H) / CPB;
                    if (j <= 8) m_byte[j-1] = rs;
                    else if (rs) begin good = 1'b1; m_mode = 0; end
                    else begin m_ferr = 1'b1; m_mode = 2; end
                end
            end
            default: if (rs) m_mode = 0;
        endcase
        if (good && (!m_valid || rx_if.i_rx_ready)) begin
            m_valid = 1'b1; m_data = m_byte; exp_q.push_back(m_byte);
        end else begin
            if (good) m_ovr = 1'b1;
            if (m_valid && rx_if.i_rx_ready) m_valid = 1'b0;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // ---------------- compare process and event monitor ----------------
    int   rise_q[$], rdata_q[$], ferr_q[$], ovr_q[$], brise_q[$], bfall_q[$];
    int   valid_hi = 0;
    logic p_valid = 1'b0, p_busy = 1'b0;

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            check("rst_valid", rx_if.o_rx_valid, 0);
            check("rst_data", rx_if.o_rx_data, 0);
            check("rst_frame_err", rx_if.o_frame_err, 0);
            check("rst_overrun", rx_if.o_overrun, 0);
            check("rst_busy", rx_if.o_busy, 0);
        end else begin
            check("valid", rx_if.o_rx_valid, m_valid);
            if (m_valid) check("data", rx_if.o_rx_data, m_data);
            check("frame_err", rx_if.o_frame_err, m_ferr);
            check("overrun", rx_if.o_overrun, m_ovr);
            check("busy", rx_if.o_busy, m_mode != 0);
            check("dbg_state_idle", rx_if.o_dbg_state == ST_IDLE, m_mode == 0);
            if (rx_if.o_rx_valid && rx_if.i_rx_ready) begin
                if (exp_q.size() == 0) check("sb_underflow", 1, 0);
                else check("sb_byte", rx_if.o_rx_data, exp_q.pop_front());
            end
        end
        if (rx_if.o_rx_valid) valid_hi++;
        if (rx_if.o_rx_valid && !p_valid) begin
            rise_q.push_back(cyc);
            rdata_q.push_back(int'(rx_if.o_rx_data));
        end
        if (rx_if.o_frame_err) ferr_q.push_back(cyc);
        if (rx_if.o_overrun) ovr_q.push_back(cyc);
        if (rx_if.o_busy && !p_busy) brise_q.push_back(cyc);
        if (!rx_if.o_busy && p_busy) bfall_q.push_back(cyc);
        p_valid = rx_if.o_rx_valid;
        p_busy  = rx_if.o_busy;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #2;
        if (rand_rdy) rx_if.i_rx_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic hold(input logic b, input int n);
        line = b;
        repeat (n) tick();
    endtask

    // t0 is the edge at which the first synchronizer flop captures the start bit.
    task automatic send(input logic [7:0] d, input logic stop_ok, output int t0);
        t0 = cyc + 1;
        hold(1'b0, CPB);
        for (int i = 0; i < 8; i++) hold(d[i], CPB);
        hold(stop_ok, CPB);
    endtask

    task automatic clear_mon();
        rise_q.delete(); rdata_q.delete(); ferr_q.delete(); ovr_q.delete();
        brise_q.delete(); bfall_q.delete();
        valid_hi = 0;
    endtask

    // ---------------- scenarios ----------------
    initial begin
        int t, ta, tb, th, r;
        rx_if.i_rx_ready = 1'b0;
        repeat (3) tick();
        check("reset_valid_pin", rx_if.o_rx_valid, 0);
        check("reset_busy_pin", rx_if.o_busy, 0);
        rst_n = 1'b1;
        hold(1'b1, 10);

        // 1: single byte, consumer always ready
        clear_mon();
        rx_if.i_rx_ready = 1'b1;
        send(8'h55, 1'b1, t);
        hold(1'b1, 20);
        check("t1_valid_count", rise_q.size(), 1);
        check("t1_valid_cycle", q_at(rise_q, 0) + 1 - t, 155);
        check("t1_valid_width", valid_hi, 1);
        check("t1_data", q_at(rdata_q, 0), 8'h55);
        check("t1_no_errors", ferr_q.size() + ovr_q.size(), 0);

        // 2: overrun while the first byte is still held
        clear_mon();
        rx_if.i_rx_ready = 1'b0;
        send(8'hA3, 1'b1, ta);
        send(8'h3C, 1'b1, tb);
        hold(1'b1, 10);
        check("t2_held_data", rx_if.o_rx_data, 8'hA3);
        check("t2_held_valid", rx_if.o_rx_valid, 1);
        check("t2_overrun_count", ovr_q.size(), 1);
        check("t2_overrun_cycle", q_at(ovr_q, 0) - tb, 154);
        rx_if.i_rx_ready = 1'b1;
        tick();
        rx_if.i_rx_ready = 1'b0;
        check("t2_valid_drop", rx_if.o_rx_valid, 0);
        hold(1'b1, 5);

        // 3: stop bit low followed by a break
        clear_mon();
        rx_if.i_rx_ready = 1'b1;
        send(8'h81, 1'b0, t);
        hold(1'b0, 40);
        th = cyc + 1;
        hold(1'b1, 10);
        check("t3_ferr_count", ferr_q.size(), 1);
        check("t3_ferr_cycle", q_at(ferr_q, 0) - t, 154);
        check("t3_no_valid", rise_q.size(), 0);
        check("t3_busy_fall", q_at(bfall_q, 0) - th, 2);

        // 4: short low glitch is rejected at the start-bit midpoint
        clear_mon();
        t = cyc + 1;
        hold(1'b0, 4);
        hold(1'b1, 20);
        check("t4_busy_rise", q_at(brise_q, 0) - t, 2);
        check("t4_busy_fall", q_at(bfall_q, 0) - t, 10);
        check("t4_quiet", rise_q.size() + ferr_q.size() + ovr_q.size(), 0);

        // 5: reset during data bit 3, then a clean frame
        clear_mon();
        hold(1'b0, CPB);
        hold(1'b1, CPB);
        hold(1'b0, CPB);
        hold(1'b1, CPB);
        hold(1'b0, H);
        rst_n = 1'b0;
        line  = 1'b1;
        tick();
        check("t5_busy_in_reset", rx_if.o_busy, 0);
        check("t5_data_in_reset", rx_if.o_rx_data, 0);
        hold(1'b1, 4);
        rst_n = 1'b1;
        hold(1'b1, 10);
        clear_mon();
        send(8'hF0, 1'b1, t);
        hold(1'b1, 20);
        check("t5_data", q_at(rdata_q, 0), 8'hF0);
        check("t5_valid_cycle", q_at(rise_q, 0) - t, 154);
        check("t5_no_ferr", ferr_q.size(), 0);

        // 6: back-to-back frames without idle time
        clear_mon();
        send(8'h00, 1'b1, ta);
        send(8'hFF, 1'b1, tb);
        hold(1'b1, 20);
        check("t6_valid_count", rise_q.size(), 2);
        check("t6_first", q_at(rdata_q, 0), 8'h00);
        check("t6_second", q_at(rdata_q, 1), 8'hFF);
        check("t6_spacing", q_at(rise_q, 1) - q_at(rise_q, 0), 160);

        // randomized traffic with a stalling consumer, glitches and breaks
        clear_mon();
        rand_rdy = 1'b1;
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                hold(1'b0, $urandom_range(1, 6));
                hold(1'b1, $urandom_range(2, 20));
            end else begin
                send(8'($urandom_range(0, 255)), r != 1, t);
                if (r == 1) hold(1'b0, $urandom_range(0, 30));
                hold(1'b1, $urandom_range((r == 1) ? 1 : 0, 25));
            end
        end
        rand_rdy = 1'b0;
        rx_if.i_rx_ready = 1'b1;
        hold(1'b1, 40);
        check("rand_delivered", rise_q.size() > 0, 1);
        check("sb_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Byte-wide asynchronous serial receiver: 8N1, LSB first, idle-high line.
- Pairs with the existing UART transmitter that drives o_uart_tx; lets sdram_test take host commands and loop transmitted data back on the board.
- Samples the line at mid-bit using a baud counter off master_clk_i.
- Presents received bytes on a valid/ready interface with a one-entry holding register; reports framing and overrun errors.

Parameters:
- CLKS_PER_BAUD, default 868: master_clk_i cycles per bit (100 MHz / 115200). Must be >= 4.
- CNT_W, default 10: baud counter width. Must satisfy 2**CNT_W > CLKS_PER_BAUD.

Ports:
- master_clk_i  in  1  sole clock; all logic on its rising edge.
- rst_n_i  in  1  reset, asynchronous assert, active-low.
- i_uart_rx  in  1  asynchronous serial line, idle high.
- o_rx_data  out  8  received byte, valid while o_rx_valid=1.
- o_rx_valid  out  1  holding register contains an unread byte.
- i_rx_ready  in  1  consumer accepts the byte this cycle.
- o_frame_err  out  1  one-cycle pulse: stop bit sampled low.
- o_overrun  out  1  one-cycle pulse: completed byte dropped because the holding register was full.
- o_busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset values:
  - All outputs 0.
  - FSM = IDLE; counters and shift register 0.
  - Both synchronizer flops 1.
  - Reset mid-frame abandons the frame with no error pulse.
- Synchronizer: i_uart_rx passes through 2 flops; the FSM sees only the synced value (rx_s).
- Constant H = floor(CLKS_PER_BAUD/2).
- IDLE:
  - rx_s=0 -> START; counter loaded with H-1.
- START:
  - Counter decrements each cycle. At 0, sample rx_s.
  - rx_s=0 -> DATA; counter loaded with CLKS_PER_BAUD-1; bit index 0.
  - rx_s=1 -> IDLE (glitch rejected, no pulses).
- DATA:
  - At counter 0, shift rx_s into the MSB of the shift register (right shift), reload the counter, increment the bit index.
  - After bit index 7 is sampled -> STOP.
- STOP:
  - At counter 0, sample rx_s.
  - rx_s=1 -> frame good; deliver the byte (see buffer rules); -> IDLE.
  - rx_s=0 -> o_frame_err pulses the next cycle; byte discarded; -> BRK.
- BRK: stay until rx_s=1, then -> IDLE. Prevents re-arming during a break condition.
- Holding register, on the good-stop cycle:
  - If o_rx_valid=0, or o_rx_valid=1 and i_rx_ready=1 in that same cycle: load o_rx_data; o_rx_valid=1 next cycle.
  - Otherwise keep the old byte unchanged and pulse o_overrun for 1 cycle.
- Handshake:
  - Transfer occurs when o_rx_valid & i_rx_ready.
  - o_rx_valid clears next cycle unless a new byte loads in that same cycle.
  - o_rx_data is stable while o_rx_valid=1 and not transferred.
- Latency:
  - Cycle 0 is the first edge at which sync flop 1 captures the low start bit.
  - Stop sample occurs at cycle 2 + H + 9*CLKS_PER_BAUD.
  - o_rx_valid rises one cycle after the stop sample.
- Back-to-back frames: the FSM returns to IDLE at the stop-bit midpoint, so a start edge half a bit later is caught. No dead time beyond 1 cycle.
- o_busy = (state != IDLE), registered with the state.

Decomposition:
- Shared package uart_pkg:
  - FSM state encoding (IDLE, START, DATA, STOP, BRK).
  - DATA_BITS=8.
  - Default baud constant CLKS_PER_BAUD_115200=868; reused by the transmitter.
- One sub-module: sync_2ff, a 2-flop synchronizer with reset value parameter (reset to 1 here). Reused for pb_i.
- The FSM, counter, shift register and holding register live in uart_rx.

Test Plan (CLKS_PER_BAUD=16, bit period 16 clocks):
1. Send 0x55, i_rx_ready=1 -> o_rx_valid high exactly 1 cycle at cycle 2+8+144+1=155 with o_rx_data=0x55; no error pulses.
2. Send 0xA3 with ready=0, then 0x3C -> o_rx_data stays 0xA3, o_overrun pulses once at the 0x3C stop sample. Then ready=1 for 1 cycle -> o_rx_valid drops next cycle.
3. Send 0x81 with stop bit driven low, then line low for 40 clocks -> o_frame_err pulses once, no o_rx_valid, o_busy high until 2 cycles after the line returns high.
4. Drive the line low for 4 clocks then high -> o_busy rises then falls by cycle 2+8+1; no valid, no pulses.
5. Assert rst_n_i=0 during data bit 3 of a frame, release, then send 0xF0 -> all outputs 0 during reset; 0xF0 received correctly, no frame error.
6. Send 0x00 then 0xFF back-to-back (no idle gap), ready=1 -> two valid pulses with 0x00 then 0xFF, spaced 160 clocks apart.
